// File: rtl/blackbox_pkg.sv
// Shared definitions for the blackbox truth-table sweeper: state encoding and widths.
package blackbox_pkg;
  localparam int NUM_COMBOS = 8;
  localparam int IDX_W      = 3;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/sweep_settle_counter.sv
// Loadable settle down-counter; zero marks the cycle on which the held combination is sampled.
module sweep_settle_counter
  import blackbox_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);
  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (en && cnt_reg != '0) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign zero = (cnt_reg == '0);
endmodule

// File: rtl/blackbox_sweeper.sv
// Sweeps a 3-input blackbox through all 8 combinations and captures its truth table.
// Optional BLACKBOX_SWEEP_CHECK_EN compares the finished table against EXPECTED.
module blackbox_sweeper
  import blackbox_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
`ifdef BLACKBOX_SWEEP_CHECK_EN
  , parameter logic [7:0] EXPECTED = 8'h00
`endif
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  output logic       c_out,
  output logic       k_out,
  output logic       f_out,
  input  logic       g_in,
  output logic       busy,
  output logic       done,
  output logic       table_valid,
  output logic [7:0] truth_table
`ifdef BLACKBOX_SWEEP_CHECK_EN
  , output logic       mismatch
  , output logic [7:0] mismatch_mask
`endif
);
  state_t                  state_reg, state_next;
  logic [IDX_W-1:0]        idx_reg;
  logic [NUM_COMBOS-1:0]   table_reg, table_next;
  logic                    valid_reg;
  logic                    cnt_zero;
  logic                    accept, sample, last;

  // abort has priority over both a new start and a pending sample
  assign accept = (state_reg == IDLE) && start && !abort;
  assign sample = (state_reg == RUN) && cnt_zero && !abort;
  assign last   = sample && (idx_reg == IDX_W'(NUM_COMBOS - 1));

  sweep_settle_counter u_settle (
    .clock    (clock),
    .reset    (reset),
    .load     (accept || sample),
    .en       (state_reg == RUN),
    .load_val (CNT_W'(SETTLE_CYCLES)),
    .zero     (cnt_zero)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_COMBOS; gi++) begin : g_table
      assign table_next[gi] = (sample && idx_reg == IDX_W'(gi)) ? g_in : table_reg[gi];
    end
  endgenerate

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (accept) state_next = RUN;
      RUN: begin
        if (abort)     state_next = IDLE;
        else if (last) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idx_reg   <= '0;
      table_reg <= '0;
      valid_reg <= 1'b0;
    end else begin
      if (accept) begin
        idx_reg   <= '0;
        table_reg <= '0;
        valid_reg <= 1'b0;
      end else begin
        table_reg <= table_next;
        if (sample && !last) idx_reg <= idx_reg + IDX_W'(1);
        if (last) valid_reg <= 1'b1;
      end
    end
  end

`ifdef BLACKBOX_SWEEP_CHECK_EN
  logic [7:0] mask_reg;

  // compare against the table including the final sample taken on this edge
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mask_reg <= '0;
    end else if (accept) begin
      mask_reg <= '0;
    end else if (last) begin
      mask_reg <= table_next ^ EXPECTED;
    end
  end

  assign mismatch_mask = mask_reg;
  assign mismatch      = |mask_reg;
`endif

  always_comb begin
    busy  = (state_reg == RUN);
    done  = (state_reg == DONE);
    c_out = 1'b0;
    k_out = 1'b0;
    f_out = 1'b0;
    if (state_reg == RUN) begin
      {c_out, k_out, f_out} = idx_reg;
    end
  end

  assign table_valid = valid_reg;
  assign truth_table = table_reg;
endmodule

// File: tb/tb_blackbox_sweeper.sv
// Directed bench for blackbox_sweeper with the blackbox modelled as g = (c & ~k) | f.
module tb_blackbox_sweeper;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic start1 = 1'b0, abort1 = 1'b0, start0 = 1'b0, abort0 = 1'b0;
  logic c1, k1, f1, g1, busy1, done1, valid1;
  logic c0, k0, f0, g0, busy0, done0, valid0;
  logic [7:0] tt1, tt0;
`ifdef BLACKBOX_SWEEP_CHECK_EN
  logic mm1, mm0;
  logic [7:0] mask1, mask0;
`endif
  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  assign g1 = (c1 & ~k1) | f1;
  assign g0 = (c0 & ~k0) | f0;

  blackbox_sweeper #(
    .SETTLE_CYCLES(1)
`ifdef BLACKBOX_SWEEP_CHECK_EN
    , .EXPECTED(8'hBA)
`endif
  ) dut1 (
    .clock(clock), .reset(reset), .start(start1), .abort(abort1),
    .c_out(c1), .k_out(k1), .f_out(f1), .g_in(g1),
    .busy(busy1), .done(done1), .table_valid(valid1), .truth_table(tt1)
`ifdef BLACKBOX_SWEEP_CHECK_EN
    , .mismatch(mm1), .mismatch_mask(mask1)
`endif
  );

  blackbox_sweeper #(
    .SETTLE_CYCLES(0)
`ifdef BLACKBOX_SWEEP_CHECK_EN
    , .EXPECTED(8'hB8)
`endif
  ) dut0 (
    .clock(clock), .reset(reset), .start(start0), .abort(abort0),
    .c_out(c0), .k_out(k0), .f_out(f0), .g_in(g0),
    .busy(busy0), .done(done0), .table_valid(valid0), .truth_table(tt0)
`ifdef BLACKBOX_SWEEP_CHECK_EN
    , .mismatch(mm0), .mismatch_mask(mask0)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  initial begin
    // reset state, sampled while reset is held low
    #12;
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    chk("rst_valid", valid1, 0);
    chk("rst_table", tt1, 8'h00);
    chk("rst_ckf", {c1, k1, f1}, 0);
    reset = 1'b1;
    tick;
    $display("txn reset released");

    // full sweep, SETTLE_CYCLES = 1
    start1 = 1'b1;
    tick;
    start1 = 1'b0;
    chk("s1_busy_e0", busy1, 1);
    for (int k = 1; k < 16; k++) begin
      tick;
      chk($sformatf("s1_ckf_%0d", k), {c1, k1, f1}, k / 2);
      chk($sformatf("s1_nodone_%0d", k), done1, 0);
    end
    tick;
    chk("s1_done", done1, 1);
    chk("s1_valid", valid1, 1);
    chk("s1_table", tt1, 8'hBA);
    chk("s1_busy_done", busy1, 0);
    chk("s1_ckf_done", {c1, k1, f1}, 0);
`ifdef BLACKBOX_SWEEP_CHECK_EN
    chk("s1_mismatch", mm1, 0);
    chk("s1_mask", mask1, 8'h00);
`endif
    tick;
    chk("s1_done_pulse", done1, 0);
    chk("s1_valid_sticky", valid1, 1);
    $display("txn sweep settle=1 table=%02h", tt1);

    // start with abort in IDLE: abort wins
    start0 = 1'b1;
    abort0 = 1'b1;
    tick;
    start0 = 1'b0;
    abort0 = 1'b0;
    chk("s0_startabort_busy", busy0, 0);

    // full sweep, SETTLE_CYCLES = 0
    start0 = 1'b1;
    tick;
    start0 = 1'b0;
    chk("s0_busy_e0", busy0, 1);
    chk("s0_ckf_0", {c0, k0, f0}, 0);
    for (int k = 1; k < 8; k++) begin
      tick;
      chk($sformatf("s0_ckf_%0d", k), {c0, k0, f0}, k);
      chk($sformatf("s0_nodone_%0d", k), done0, 0);
    end
    tick;
    chk("s0_done", done0, 1);
    chk("s0_table", tt0, 8'hBA);
    chk("s0_valid", valid0, 1);
`ifdef BLACKBOX_SWEEP_CHECK_EN
    chk("s0_mismatch", mm0, 1);
    chk("s0_mask", mask0, 8'h02);
`endif
    $display("txn sweep settle=0 table=%02h", tt0);

    // abort seen at edge E0+5
    start1 = 1'b1;
    tick;
    start1 = 1'b0;
    chk("ab_valid_cleared", valid1, 0);
    chk("ab_table_cleared", tt1, 8'h00);
    repeat (4) tick;
    abort1 = 1'b1;
    tick;
    abort1 = 1'b0;
    chk("ab_busy", busy1, 0);
    chk("ab_done", done1, 0);
    chk("ab_valid", valid1, 0);
    chk("ab_partial", tt1, 8'h02);
    tick;
    chk("ab_done_after", done1, 0);
    chk("ab_busy_after", busy1, 0);
    start1 = 1'b1;
    tick;
    start1 = 1'b0;
    repeat (15) tick;
    chk("ab_re_nodone", done1, 0);
    tick;
    chk("ab_re_done", done1, 1);
    chk("ab_re_table", tt1, 8'hBA);
    $display("txn abort then resweep table=%02h", tt1);
    tick;

    // start held high: one sweep per IDLE entry, 18 cycles apart
    start1 = 1'b1;
    tick;
    for (int k = 1; k <= 40; k++) begin
      tick;
      chk($sformatf("hold_done_%0d", k), done1, ((k % 18) == 16) ? 1 : 0);
      chk($sformatf("hold_busy_%0d", k), busy1, ((k % 18) < 16) ? 1 : 0);
    end
    start1 = 1'b0;
    abort1 = 1'b1;
    tick;
    abort1 = 1'b0;
    chk("hold_abort_busy", busy1, 0);
    $display("txn start held, sweeps spaced 18 cycles");

    // asynchronous reset mid-RUN at idx = 3
    start1 = 1'b1;
    tick;
    start1 = 1'b0;
    repeat (7) tick;
    chk("ar_idx3", {c1, k1, f1}, 3);
    #2 reset = 1'b0;
    #1;
    chk("ar_ckf", {c1, k1, f1}, 0);
    chk("ar_busy", busy1, 0);
    chk("ar_table", tt1, 8'h00);
    chk("ar_valid", valid1, 0);
    chk("ar_done", done1, 0);
    #2 reset = 1'b1;
    tick;
    chk("ar_idle", busy1, 0);
    repeat (3) tick;
    chk("ar_idle_stays", busy1, 0);
    $display("txn async reset mid-run");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/blackbox_sweeper.md
Name: blackbox_sweeper

Overview:
- Sequencer that drives the 3-input combinational blackbox (inputs c, k, f; output g) through all 8 input combinations.
- Samples g after a programmable settle time and assembles an 8-bit truth table.
- Sits between a host/bench-side start/done handshake and the blackbox instance; replaces hand-written exhaustive stimulus with a reusable hardware sweep.

Parameters:
- SETTLE_CYCLES, 1, extra cycles each combination is held before g is sampled; legal range 0..15.

Ports:
- clock  input  1  single system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- start  input  1  request a sweep; honoured only in IDLE.
- abort  input  1  cancel a sweep in progress; returns to IDLE.
- c_out  output  1  blackbox c input (idx[2]).
- k_out  output  1  blackbox k input (idx[1]).
- f_out  output  1  blackbox f input (idx[0]).
- g_in  input  1  blackbox g output.
- busy  output  1  high while a sweep is in RUN.
- done  output  1  one-cycle pulse when a sweep completes.
- table_valid  output  1  sticky: truth_table holds a complete sweep.
- truth_table  output  8  bit i = g sampled with {c,k,f} = i.

Behaviour:
- Reset (async, reset == 0):
  - State = IDLE; idx = 0; settle counter = 0.
  - All outputs = 0, including truth_table = 8'h00.
- States: IDLE, RUN, DONE.
- IDLE:
  - c/k/f outputs = 0.
  - On start == 1 and abort == 0: go to RUN, idx = 0, cnt = SETTLE_CYCLES, table_valid cleared, truth_table cleared.
  - start together with abort in IDLE: abort wins; stay in IDLE.
- RUN:
  - {c_out, k_out, f_out} = idx (registered); busy = 1.
  - Each edge: if cnt != 0, cnt decrements.
  - If cnt == 0: truth_table[idx] <= g_in and cnt reloads to SETTLE_CYCLES.
    - If idx == 7: go to DONE.
    - Otherwise idx increments.
- Timing:
  - Each combination is held for exactly SETTLE_CYCLES+1 cycles.
  - Combination i is sampled at edge E0 + (SETTLE_CYCLES+1)*(i+1), where E0 is the edge that accepted start.
- DONE:
  - Lasts exactly one cycle; done = 1, table_valid = 1, c/k/f = 0, busy = 0.
  - Next state IDLE.
  - start during DONE is ignored.
- Abort:
  - abort in RUN: next state IDLE, busy = 0, no done pulse, table_valid stays 0.
  - Partial truth_table is retained but is not valid.
- start while busy: ignored; no restart.
- idx is 3 bits and does not wrap in RUN; the idx == 7 sample terminates the sweep.
- The settle counter is 4 bits.

Optional Feature:
- Macro: BLACKBOX_SWEEP_CHECK_EN.
- With the macro defined:
  - Add parameter EXPECTED (8 bits, default 8'h00).
  - Add output mismatch (1 bit) and output mismatch_mask (8 bits).
  - Both are updated in the same edge as done: mismatch_mask = truth_table ^ EXPECTED; mismatch = |mismatch_mask.
  - Both are cleared on start and on reset.
- Without the macro: these ports and parameter do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package blackbox_pkg:
  - State encoding constants IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - NUM_COMBOS = 8; IDX_W = 3; CNT_W = 4.
- One natural sub-module, sweep_settle_counter: loadable down-counter with a zero flag, driving the sample strobe.
- FSM, index register and truth table stay in the top module.

Test Plan:
- Reset with reset = 0 mid-RUN at idx = 3 -> all outputs 0 immediately (asynchronous); IDLE after release.
- Blackbox modelled as g = (c & ~k) | f, SETTLE_CYCLES = 1, start pulsed at E0 -> done high for one cycle after edge E0+16, truth_table = 8'hBA, table_valid = 1.
- SETTLE_CYCLES = 0, same model -> done after edge E0+8; c/k/f step 0..7 on consecutive cycles; truth_table = 8'hBA.
- abort asserted at edge E0+5 (SETTLE_CYCLES = 1) -> busy = 0 next cycle, no done pulse, table_valid = 0; a subsequent start produces a full 8'hBA sweep.
- start held high continuously -> exactly one sweep per IDLE entry, starts spaced 18 cycles apart, start ignored during RUN/DONE.
- BLACKBOX_SWEEP_CHECK_EN defined:
  - EXPECTED = 8'hBA -> mismatch = 0.
  - EXPECTED = 8'hB8 -> mismatch = 1, mismatch_mask = 8'h02.
